// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - CPU-side load/store initiator for the shared tristate memory bus
module mem_bus_master #(
    parameter int DWIDTH     = 32,
    parameter int CPUAWIDTH  = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rw,
    input  logic [CPUAWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0]    req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DWIDTH-1:0]    resp_rdata,
    output logic                 resp_err,
    output logic [CPUAWIDTH-1:0] addr,
    output logic                 rw,
    output logic                 valid,
    inout  wire  [DWIDTH-1:0]    data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(RD_LATENCY - 1);

    state_t                 state_q;
    logic [CPUAWIDTH-1:0]   addr_lat_q;
    logic [DWIDTH-1:0]      wdata_q;
    logic                   last_rd_q;
    logic [3:0]             cnt_q;
    logic                   resp_valid_q;
    logic [DWIDTH-1:0]      resp_rdata_q;
    logic                   resp_err_q;
    logic [CPUAWIDTH-1:0]   bus_addr_q;
    logic                   bus_rw_q;
    logic                   bus_valid_q;
    logic                   drive_q;

    // Ready is forced low while reset is asserted so nothing is accepted in that cycle.
    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign addr       = bus_addr_q;
    assign rw         = bus_rw_q;
    assign valid      = bus_valid_q;
    assign data       = drive_q ? wdata_q : {DWIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_lat_q   <= '0;
            wdata_q      <= '0;
            last_rd_q    <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            bus_addr_q   <= '0;
            bus_rw_q     <= 1'b0;
            bus_valid_q  <= 1'b0;
            drive_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_lat_q   <= req_addr;
                        wdata_q      <= req_wdata;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        if (req_addr[1:0] != 2'b00) begin
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (req_rw) begin
                            cnt_q       <= '0;
                            bus_valid_q <= 1'b1;
                            bus_rw_q    <= 1'b1;
                            bus_addr_q  <= req_addr;
                            state_q     <= S_READ;
                        end else if (last_rd_q) begin
                            state_q <= S_TURN;
                        end else begin
                            bus_valid_q <= 1'b1;
                            bus_rw_q    <= 1'b0;
                            bus_addr_q  <= req_addr;
                            drive_q     <= 1'b1;
                            state_q     <= S_WRITE;
                        end
                    end
                end
                S_TURN: begin
                    bus_valid_q <= 1'b1;
                    bus_rw_q    <= 1'b0;
                    bus_addr_q  <= addr_lat_q;
                    drive_q     <= 1'b1;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    bus_valid_q  <= 1'b0;
                    bus_addr_q   <= '0;
                    drive_q      <= 1'b0;
                    last_rd_q    <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_READ: begin
                    if (cnt_q == LAST_CNT) begin
                        resp_rdata_q <= data;
                        bus_valid_q  <= 1'b0;
                        bus_rw_q     <= 1'b0;
                        bus_addr_q   <= '0;
                        last_rd_q    <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - randomized self-checking bench for mem_bus_master
module tb_mem_bus_master;

    logic        clk;
    logic        reset;
    int          checks;
    int          errors;

    logic        req_valid, req_ready, req_rw, resp_valid, resp_ready, resp_err, rw, valid;
    logic [31:0] req_addr, req_wdata, resp_rdata, addr;
    tri1  [31:0] data;

    logic        l3_req_valid, l3_req_ready, l3_resp_valid, l3_resp_ready, l3_resp_err, l3_rw, l3_valid;
    logic [31:0] l3_resp_rdata, l3_addr;
    tri1  [31:0] l3_data;
    logic [15:0] l3_cnt;

    logic [31:0] smem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        m_last_rd;

    mem_bus_master #(.DWIDTH(32), .CPUAWIDTH(32), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .addr(addr), .rw(rw), .valid(valid), .data(data)
    );

    mem_bus_master #(.DWIDTH(32), .CPUAWIDTH(32), .RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
        .req_rw(1'b1), .req_addr(32'h40), .req_wdata(32'h0),
        .resp_valid(l3_resp_valid), .resp_ready(l3_resp_ready), .resp_rdata(l3_resp_rdata),
        .resp_err(l3_resp_err), .addr(l3_addr), .rw(l3_rw), .valid(l3_valid), .data(l3_data)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h0100_0193) ^ 32'h5BD1_E995;
    endfunction

    // Bus slave for the latency-1 master: a 64-word RAM
    assign data = (valid && rw) ? smem[addr[7:2]] : 32'hzzzz_zzzz;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) smem[i] <= init_word(i);
        end else if (valid && !rw) begin
            smem[addr[7:2]] <= data;
        end
    end

    // Bus slave for the latency-3 master returns a per-cycle count to expose the sampling edge
    assign l3_data = (l3_valid && l3_rw) ? {16'hC0DE, l3_cnt} : 32'hzzzz_zzzz;
    always @(posedge clk) l3_cnt <= (l3_valid && l3_rw) ? l3_cnt + 16'd1 : 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic t_rw, input logic [31:0] t_a, input logic [31:0] t_wd, input int hold,
                       output int lat, output int vfirst, output int vcnt, output logic [31:0] vaddr,
                       output logic vrw, output logic [31:0] vdata, output int idle_bad,
                       output int stab_bad, output logic [31:0] rd, output logic er, output int acc_wait);
        lat = -1; vfirst = -1; vcnt = 0; vaddr = '0; vrw = 1'b0; vdata = '0;
        idle_bad = 0; stab_bad = 0; rd = '0; er = 1'b0; acc_wait = 0;
        req_rw = t_rw; req_addr = t_a; req_wdata = t_wd; req_valid = 1'b1;
        resp_ready = (hold == 0);
        while (!req_ready && acc_wait < 20) begin
            step;
            acc_wait++;
        end
        step;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            if (valid) begin
                if (vcnt == 0) vfirst = k;
                vcnt++;
                vaddr = addr; vrw = rw; vdata = data;
            end else if (addr != 0 || rw != 1'b0 || data !== 32'hFFFF_FFFF) begin
                idle_bad++;
            end
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err;
            end else begin
                step;
            end
        end
        if (lat >= 0) begin
            for (int h = 0; h < hold; h++) begin
                step;
                if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready || valid)
                    stab_bad++;
            end
        end
        resp_ready = 1'b1;
        step;
        resp_ready = 1'b0;
    endtask

    task automatic model_commit(input logic t_rw, input logic [31:0] t_a, input logic [31:0] t_wd);
        if (t_a[1:0] == 2'b00) begin
            if (t_rw) m_last_rd = 1'b1;
            else begin
                m_last_rd = 1'b0;
                ref_mem[t_a[7:2]] = t_wd;
            end
        end
    endtask

    int          lat, vfirst, vcnt, idle_bad, stab_bad, acc_wait;
    logic [31:0] vaddr, vdata, rd;
    logic        vrw, er;

    task automatic test_reset;
        reset = 1'b1;
        step;
        step;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++;
            $display("FAIL reset_resp: got valid=%b err=%b rdata=%h expected 0/0/0", resp_valid, resp_err, resp_rdata); end
        checks++; if (valid !== 1'b0 || rw !== 1'b0 || addr !== 32'h0) begin errors++;
            $display("FAIL reset_bus: got valid=%b rw=%b addr=%h expected 0/0/0", valid, rw, addr); end
        checks++; if (data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_data_released: got %h expected ffffffff", data); end
        reset = 1'b0;
        step;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", req_ready); end
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        m_last_rd = 1'b0;
    endtask

    task automatic test_write_read;
        txn(1'b0, 32'h10, 32'hDEAD_BEEF, 0, lat, vfirst, vcnt, vaddr, vrw, vdata, idle_bad, stab_bad, rd, er, acc_wait);
        model_commit(1'b0, 32'h10, 32'hDEAD_BEEF);
        checks++; if (vcnt !== 1 || vfirst !== 1) begin errors++; $display("FAIL wr_valid_cycles: got cnt=%0d first=%0d expected 1/1", vcnt, vfirst); end
        checks++; if (vrw !== 1'b0 || vaddr !== 32'h10 || vdata !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL wr_bus: got rw=%b addr=%h data=%h expected 0/00000010/deadbeef", vrw, vaddr, vdata); end
        checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin errors++;
            $display("FAIL wr_resp: got lat=%0d err=%b rdata=%h expected 2/0/0", lat, er, rd); end
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL wr_idle_bus: got %0d bad cycles expected 0", idle_bad); end
        txn(1'b1, 32'h10, 32'h0, 0, lat, vfirst, vcnt, vaddr, vrw, vdata, idle_bad, stab_bad, rd, er, acc_wait);
        model_commit(1'b1, 32'h10, 32'h0);
        checks++; if (vcnt !== 1 || vrw !== 1'b1 || vaddr !== 32'h10 || vdata !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL rd_bus: got cnt=%0d rw=%b addr=%h data=%h expected 1/1/00000010/deadbeef", vcnt, vrw, vaddr, vdata); end
        checks++; if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++;
            $display("FAIL rd_resp: got lat=%0d rdata=%h err=%b expected 2/deadbeef/0", lat, rd, er); end
    endtask

    task automatic test_turnaround;
        txn(1'b1, 32'h20, 32'h0, 0, lat, vfirst, vcnt, vaddr, vrw, vdata, idle_bad, stab_bad, rd, er, acc_wait);
        checks++; if (rd !== ref_mem[8]) begin errors++; $display("FAIL turn_rd_data: got %h expected %h", rd, ref_mem[8]); end
        model_commit(1'b1, 32'h20, 32'h0);
        txn(1'b0, 32'h24, 32'h1234_5678, 0, lat, vfirst, vcnt, vaddr, vrw, vdata, idle_bad, stab_bad, rd, er, acc_wait);
        model_commit(1'b0, 32'h24, 32'h1234_5678);
        checks++; if (acc_wait !== 0) begin errors++; $display("FAIL turn_accept: got wait=%0d expected 0", acc_wait); end
        checks++; if (vfirst !== 2 || vcnt !== 1 || vdata !== 32'h1234_5678 || vaddr !== 32'h24) begin errors++;
            $display("FAIL turn_write_bus: got first=%0d cnt=%0d data=%h addr=%h expected 2/1/12345678/00000024", vfirst, vcnt, vdata, vaddr); end
        checks++; if (lat !== 3 || idle_bad !== 0) begin errors++;
            $display("FAIL turn_write_resp: got lat=%0d idle_bad=%0d expected 3/0", lat, idle_bad); end
    endtask

    task automatic test_misaligned;
        txn(1'b1, 32'h13, 32'h0, 0, lat, vfirst, vcnt, vaddr, vrw, vdata, idle_bad, stab_bad, rd, er, acc_wait);
        checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++;
            $display("FAIL misaligned_resp: got lat=%0d err=%b rdata=%h expected 1/1/0", lat, er, rd); end
        checks++; if (vcnt !== 0 || idle_bad !== 0) begin errors++;
            $display("FAIL misaligned_bus: got valid_cycles=%0d idle_bad=%0d expected 0/0", vcnt, idle_bad); end
    endtask

    task automatic test_backpressure;
        txn(1'b1, 32'h30, 32'h0, 5, lat, vfirst, vcnt, vaddr, vrw, vdata, idle_bad, stab_bad, rd, er, acc_wait);
        model_commit(1'b1, 32'h30, 32'h0);
        checks++; if (lat !== 2 || rd !== ref_mem[12]) begin errors++;
            $display("FAIL bp_resp: got lat=%0d rdata=%h expected 2/%h", lat, rd, ref_mem[12]); end
        checks++; if (stab_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stab_bad); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", req_ready); end
    endtask

    task automatic test_random;
        logic        t_rw;
        logic [31:0] t_a, t_wd, e_rd;
        int          e_lat, e_cnt, e_first, hold, bad;
        bad = 0;
        for (int n = 0; n < 60; n++) begin
            t_rw = 1'($urandom_range(0, 1));
            t_a  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 7) == 0) t_a[1:0] = 2'($urandom_range(1, 3));
            t_wd = $urandom;
            if (t_wd == 32'hFFFF_FFFF) t_wd = 32'h0;
            hold = $urandom_range(0, 3);
            if (t_a[1:0] != 2'b00) begin
                e_lat = 1; e_cnt = 0; e_first = -1; e_rd = 32'h0;
            end else if (t_rw) begin
                e_lat = 2; e_cnt = 1; e_first = 1; e_rd = ref_mem[t_a[7:2]];
            end else begin
                e_lat = m_last_rd ? 3 : 2; e_cnt = 1; e_first = m_last_rd ? 2 : 1; e_rd = 32'h0;
            end
            txn(t_rw, t_a, t_wd, hold, lat, vfirst, vcnt, vaddr, vrw, vdata, idle_bad, stab_bad, rd, er, acc_wait);
            model_commit(t_rw, t_a, t_wd);
            checks++;
            if (lat !== e_lat || vcnt !== e_cnt || vfirst !== e_first || rd !== e_rd ||
                er !== (t_a[1:0] != 2'b00) || idle_bad !== 0 || stab_bad !== 0 || acc_wait !== 0 ||
                (e_cnt == 1 && (vaddr !== t_a || vrw !== t_rw || (!t_rw && vdata !== t_wd)))) begin
                errors++; bad++;
                $display("FAIL random_txn %0d rw=%b a=%h: got lat=%0d cnt=%0d first=%0d rdata=%h err=%b idle=%0d stab=%0d expected lat=%0d cnt=%0d first=%0d rdata=%h",
                         n, t_rw, t_a, lat, vcnt, vfirst, rd, er, idle_bad, stab_bad, e_lat, e_cnt, e_first, e_rd);
            end
        end
    endtask

    task automatic test_lat3;
        int k, cnt, first, last, l3lat;
        logic [31:0] l3rd;
        cnt = 0; first = -1; last = -1; l3lat = -1; l3rd = '0; k = 0;
        l3_resp_ready = 1'b1;
        l3_req_valid = 1'b1;
        while (!l3_req_ready && k < 20) begin step; k++; end
        step;
        l3_req_valid = 1'b0;
        for (k = 1; k <= 20 && l3lat < 0; k++) begin
            if (l3_valid) begin
                if (first < 0) first = k;
                last = k;
                cnt++;
            end
            if (l3_resp_valid) begin
                l3lat = k; l3rd = l3_resp_rdata;
            end else begin
                step;
            end
        end
        step;
        checks++; if (cnt !== 3 || first !== 1 || last !== 3) begin errors++;
            $display("FAIL lat3_valid: got cnt=%0d first=%0d last=%0d expected 3/1/3", cnt, first, last); end
        checks++; if (l3lat !== 4 || l3rd !== 32'hC0DE_0002) begin errors++;
            $display("FAIL lat3_resp: got lat=%0d rdata=%h expected 4/c0de0002", l3lat, l3rd); end
    endtask

    task automatic test_reset_mid_read;
        int seen;
        seen = 0;
        l3_req_valid = 1'b1;
        step;
        l3_req_valid = 1'b0;
        step;
        reset = 1'b1;
        step;
        checks++; if (l3_valid !== 1'b0 || l3_data !== 32'hFFFF_FFFF || l3_resp_valid !== 1'b0) begin errors++;
            $display("FAIL midreset_bus: got valid=%b data=%h resp_valid=%b expected 0/ffffffff/0", l3_valid, l3_data, l3_resp_valid); end
        reset = 1'b0;
        step;
        checks++; if (l3_req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", l3_req_ready); end
        for (int i = 0; i < 5; i++) begin
            if (l3_resp_valid || l3_valid) seen++;
            step;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_resp: got %0d active cycles expected 0", seen); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        l3_req_valid = 1'b0; l3_resp_ready = 1'b1;
        m_last_rd = 1'b0;
        test_reset;
        test_write_read;
        test_turnaround;
        test_misaligned;
        test_backpressure;
        test_random;
        test_lat3;
        test_reset_mid_read;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
